mcu_buffer_reader: RTL
======================

MCU_BUFFER_READER -- requirements
Module: mcu_buffer_reader

Interface
REQ-001 Parameter: width_pix, 320, image width in pixels; a multiple of 8 and of 8*num_ebr.
REQ-002 Parameter: num_ebr, 5, EBR blocks per buffer half.
REQ-003 Parameter: ebr_size, 512, bytes per EBR; width_pix*8 SHALL equal num_ebr*ebr_size.
REQ-004 clock  input  1  sole clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frontbuffer_select  input  1  buffer half currently being written by the camera ingester.
REQ-007 frame_active  input  1  synchronized vsync; 0 is inter-frame.
REQ-008 rd_en  output  1  EBR read strobe.
REQ-009 rd_buffer_select  output  1  buffer half being read.
REQ-010 rd_block_select  output  clog2(num_ebr)  EBR index.
REQ-011 rd_addr  output  clog2(ebr_size)  EBR address.
REQ-012 rd_data  input  8*num_ebr  per-EBR read data, valid one cycle after rd_en; EBR k occupies bits [8k+7:8k].
REQ-013 pix_valid / pix_ready  output / input  1 / 1  output stream handshake.
REQ-014 pix_data  output  8  pixel value.
REQ-015 pix_first / pix_last  output  1 / 1  marks pixel 0 / pixel 63 of an MCU.
REQ-016 overrun  output  1  sticky error flag.

Function
REQ-017 Storage layout: MCU m (0..width_pix/8-1) of a row SHALL be read from EBR (m mod num_ebr) at address (m div num_ebr)*64 + py*8 + px.
REQ-018 Read order: MCUs 0,1,2,... ascending; within each MCU, raster order py 0..7, px 0..7.
REQ-019 A change of frontbuffer_select while frame_active=1 SHALL mark the previous value's half as a completed MCU row; changes while frame_active=0 SHALL be ignored.
REQ-020 FSM states: IDLE, READ, DRAIN. IDLE->READ on a completed row (or pending flag); READ->DRAIN after the last address is issued; DRAIN->IDLE once the skid buffer is empty and no read is in flight.
REQ-021 One pending completed-row flag SHALL be held while not in IDLE; it is consumed on DRAIN->IDLE, entering READ on the next cycle.
REQ-022 EBR read latency is exactly 1 cycle; returned data SHALL be selected by the registered block index of the issuing cycle.
REQ-023 A 2-entry skid buffer SHALL be used; rd_en SHALL assert only when occupancy plus in-flight reads is less than 2, so no data is ever dropped.
REQ-024 A transfer occurs when pix_valid and pix_ready are both 1; pix_data, pix_first and pix_last SHALL remain stable while pix_valid=1 and pix_ready=0.
REQ-025 With pix_ready held at 1, pixels SHALL stream at 1 per cycle; the first pix_valid follows the start toggle by at most 3 cycles.
REQ-026 Address counters SHALL wrap: px 7->0 increments py; py 7->0 increments the MCU index; the last MCU ends the row.
REQ-027 frame_active falling while in READ or DRAIN SHALL NOT abort the row in progress.

Reset
REQ-028 On reset: state IDLE; pending=0; counters=0; skid buffer empty; rd_en=0; pix_valid=0; pix_first=0; pix_last=0; overrun=0; rd_buffer_select=0.
REQ-029 Reset asserted mid-row SHALL discard all buffered and in-flight data; the next cycle is the reset state.

Configuration
REQ-030 Macro MCU_BUFFER_READER_OVERRUN_EN defined: a completed-row event while pending=1 SHALL set overrun and hold it until reset; the event is dropped.
REQ-031 Macro absent: overrun SHALL be constant 0; the event is silently dropped.

Structure
REQ-032 A shared package SHALL hold the layout constants (pixels per MCU 64, MCU edge 8) and the FSM state encoding, shared with the camera ingester.
REQ-033 The 2-entry skid buffer SHALL be a sub-module, mcu_skid_buffer, parameterized on data width (10 bits: data, first, last).

Verification
REQ-034 Toggle 0->1 with frame_active=1 and pix_ready=1 -> 2560 pixels from half 0; the first four reads hit EBR0 addr 0..3; MCU 5 starts at EBR0 addr 64; pix_last on every 64th pixel.
REQ-035 pix_ready randomly low at 50% -> the output sequence is identical to REQ-034 and no pixel is duplicated or lost.
REQ-036 Toggle while frame_active=0 -> no rd_en and no pix_valid.
REQ-037 Second toggle during READ, then a third before consumption -> with the macro, the second row is read after the first and overrun=1; without it, overrun stays 0.
REQ-038 Reset asserted after pixel 100 -> next cycle pix_valid=0 and rd_en=0; a new toggle restarts at MCU 0, EBR0, addr 0.

Source files
------------

// File: rtl/mcu_buffer_reader_pkg.sv
// Layout constants and FSM encoding shared by the MCU buffer reader and the camera ingester.
package mcu_buffer_reader_pkg;

  localparam int MCU_PIX  = 64;
  localparam int MCU_EDGE = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } pix_t;

  localparam int PIX_W = $bits(pix_t);

endpackage

// File: rtl/mcu_buffer_reader_skid.sv
// Two-entry skid FIFO between the EBR read pipe and the pixel stream; head is held until popped.
module mcu_skid_buffer
  import mcu_buffer_reader_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  // The producer only issues a read when a slot is guaranteed, so push never sees a full buffer.
  always_ff @(posedge clock) begin
    if (in_valid) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count <= count + 2'(in_valid) - 2'(pop);
    end
  end

endmodule

// File: rtl/mcu_buffer_reader.sv
// Streams one completed MCU row out of the EBR ping-pong buffer as a valid/ready pixel stream.
// Define MCU_BUFFER_READER_OVERRUN_EN to get a sticky flag for row events dropped while one is pending.
module mcu_buffer_reader
  import mcu_buffer_reader_pkg::*;
#(
  parameter int width_pix = 320,
  parameter int num_ebr   = 5,
  parameter int ebr_size  = 512,
  localparam int BW = (num_ebr > 1) ? $clog2(num_ebr) : 1,
  localparam int AW = $clog2(ebr_size)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frontbuffer_select,
  input  logic                 frame_active,
  output logic                 rd_en,
  output logic                 rd_buffer_select,
  output logic [BW-1:0]        rd_block_select,
  output logic [AW-1:0]        rd_addr,
  input  logic [8*num_ebr-1:0] rd_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [7:0]           pix_data,
  output logic                 pix_first,
  output logic                 pix_last,
  output logic                 overrun
);

  localparam int         NGRP     = width_pix / (MCU_EDGE * num_ebr);
  localparam int         GW       = AW - $clog2(MCU_PIX);
  localparam logic [2:0] EDGE_MAX = 3'(MCU_EDGE - 1);

  rd_state_t     state, state_nxt;
  logic          fb_q, evt, start, pending, pend_half;
  logic [2:0]    px, py;
  logic [BW-1:0] blk, blk_q;
  logic [GW-1:0] grp;
  logic          last_addr, issue, pop, rd_vld, first_q, last_q;
  logic [1:0]    occ;
  logic [2:0]    fill;
  pix_t          push_pix, head;

  assign evt       = frame_active && (frontbuffer_select != fb_q);
  assign start     = evt || pending;
  assign pop       = pix_valid && pix_ready;
  assign last_addr = (px == EDGE_MAX) && (py == EDGE_MAX) &&
                     (blk == BW'(num_ebr - 1)) && (grp == GW'(NGRP - 1));
  // Counting this cycle's pop lets a read issue every cycle while the consumer keeps up.
  assign fill      = {1'b0, occ} + {2'b0, rd_vld} - {2'b0, pop};

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (issue && last_addr) state_nxt = ST_DRAIN;
      ST_DRAIN: if (occ == 2'd0 && !rd_vld) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue = (state == ST_READ) && (fill < 3'd2);
    rd_en = issue;
  end

  assign rd_block_select = blk;
  assign rd_addr         = {grp, py, px};

  always_ff @(posedge clock) fb_q <= frontbuffer_select;

  always_ff @(posedge clock) begin
    if (reset) begin
      pending          <= 1'b0;
      pend_half        <= 1'b0;
      rd_buffer_select <= 1'b0;
      px <= '0; py <= '0; blk <= '0; grp <= '0;
      rd_vld  <= 1'b0;
      blk_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      // The completed half is the value frontbuffer_select held before the toggle.
      if (state == ST_IDLE && start) begin
        pending          <= 1'b0;
        rd_buffer_select <= pending ? pend_half : fb_q;
      end else if (evt && !pending) begin
        pending   <= 1'b1;
        pend_half <= fb_q;
      end
      rd_vld <= issue;
      if (issue) begin
        blk_q   <= blk;
        first_q <= (px == 3'd0) && (py == 3'd0);
        last_q  <= (px == EDGE_MAX) && (py == EDGE_MAX);
        px      <= px + 3'd1;
        if (px == EDGE_MAX) begin
          py <= py + 3'd1;
          if (py == EDGE_MAX) begin
            if (blk == BW'(num_ebr - 1)) begin
              blk <= '0;
              grp <= (grp == GW'(NGRP - 1)) ? '0 : grp + 1'b1;
            end else begin
              blk <= blk + 1'b1;
            end
          end
        end
      end
    end
  end

  assign push_pix = '{data: rd_data[{blk_q, 3'b000} +: 8], first: first_q, last: last_q};

  mcu_skid_buffer #(.W(PIX_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_vld),
    .in_data   (push_pix),
    .out_valid (pix_valid),
    .out_ready (pix_ready),
    .out_data  (head),
    .count     (occ)
  );

  assign pix_data  = head.data;
  assign pix_first = pix_valid && head.first;
  assign pix_last  = pix_valid && head.last;

`ifdef MCU_BUFFER_READER_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge clock) begin
    if (reset)               overrun_q <= 1'b0;
    else if (evt && pending) overrun_q <= 1'b1;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
